// File: rtl/rob_ctrl_pkg.sv
// Shared sizes, FSM encoding and entry layout for the reorder buffer.
// The exp field exists only when ROB_EXP_EN is defined.
package rob_ctrl_pkg;

    localparam int ROB_DEPTH      = 8;
    localparam int GPR_ADDR_WIDTH = 5;
    localparam int TAG_W          = $clog2(ROB_DEPTH);
    localparam int PTR_W          = TAG_W + 1;

    typedef logic [TAG_W-1:0]          tag_t;
    typedef logic [PTR_W-1:0]          ptr_t;
    typedef logic [GPR_ADDR_WIDTH-1:0] gpr_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } rob_state_e;

    typedef struct packed {
        logic valid;
        logic done;
        gpr_t dst_addr;
        logic dst_wen;
        logic br_taken;
`ifdef ROB_EXP_EN
        logic exp;
`endif
    } rob_entry_t;

endpackage

// File: rtl/rob_ctrl_if.sv
// Dispatch, writeback and RAT-side signals of the reorder buffer.
// slave is the ROB side, master is the dispatch/writeback side.
interface rob_ctrl_if;
    import rob_ctrl_pkg::*;

    logic id_alloc_valid;
    gpr_t id_dst_addr;
    logic id_dst_wen;
    logic alloc_ready;
    logic allocate_en;
    tag_t rob_alloc_tag_2rat;
    gpr_t rob_alloc_dst_addr_2rat;
    logic rob_alloc_dst_wen_2rat;
    logic wb_en;
    tag_t wb_tag;
    logic wb_br_taken;
    logic wb_exp;
    logic commit_en;
    gpr_t rob_commit_dst_addr_2rat;
    logic rob_commit_br_taken;
    logic rob_commit_exp_en;
    tag_t rob_commit_tag;
    logic rob_retire;

    modport master (
        output id_alloc_valid, id_dst_addr, id_dst_wen,
        output wb_en, wb_tag, wb_br_taken, wb_exp,
        input  alloc_ready, allocate_en, rob_alloc_tag_2rat,
        input  rob_alloc_dst_addr_2rat, rob_alloc_dst_wen_2rat,
        input  commit_en, rob_commit_dst_addr_2rat, rob_commit_br_taken,
        input  rob_commit_exp_en, rob_commit_tag, rob_retire
    );

    modport slave (
        input  id_alloc_valid, id_dst_addr, id_dst_wen,
        input  wb_en, wb_tag, wb_br_taken, wb_exp,
        output alloc_ready, allocate_en, rob_alloc_tag_2rat,
        output rob_alloc_dst_addr_2rat, rob_alloc_dst_wen_2rat,
        output commit_en, rob_commit_dst_addr_2rat, rob_commit_br_taken,
        output rob_commit_exp_en, rob_commit_tag, rob_retire
    );

endinterface

// File: rtl/rob_last_writer.sv
// Clears the commit qualifier when any other live entry
// still maps the head's destination register.
module rob_last_writer
    import rob_ctrl_pkg::*;
(
    input  rob_entry_t [ROB_DEPTH-1:0] ent,
    input  tag_t                       head,
    output logic                       last
);

    always_comb begin
        last = 1'b1;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            if (tag_t'(i) != head && ent[i].valid && ent[i].dst_wen &&
                ent[i].dst_addr == ent[head].dst_addr)
                last = 1'b0;
        end
    end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: tag allocation, in-order retire, flush.
// Define ROB_EXP_EN to track exceptions alongside branch redirects.
module rob_ctrl
    import rob_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    rob_ctrl_if.slave bus
);

    rob_state_e                 state;
    ptr_t                       head;
    ptr_t                       tail;
    rob_entry_t [ROB_DEPTH-1:0] ent;

    tag_t       head_tag;
    tag_t       tail_tag;
    rob_entry_t head_e;
    rob_entry_t new_e;
    logic       full;
    logic       alloc_wen;
    logic       retire;
    logic       last;
    logic       head_exp;
    logic       flush;

    assign head_tag  = head[TAG_W-1:0];
    assign tail_tag  = tail[TAG_W-1:0];
    assign head_e    = ent[head_tag];
    assign full      = (head_tag == tail_tag) && (head[TAG_W] != tail[TAG_W]);
    assign alloc_wen = bus.id_dst_wen && (bus.id_dst_addr != '0);

    // rst_n gates ready so every output reads 0 while reset is held
    assign bus.alloc_ready             = rst_n && (state == RUN) && !full;
    assign bus.allocate_en             = bus.id_alloc_valid && bus.alloc_ready;
    assign bus.rob_alloc_tag_2rat      = tail_tag;
    assign bus.rob_alloc_dst_addr_2rat = bus.allocate_en ? bus.id_dst_addr : '0;
    assign bus.rob_alloc_dst_wen_2rat  = bus.allocate_en && alloc_wen;

`ifdef ROB_EXP_EN
    assign head_exp = head_e.exp;
`else
    logic unused_exp;
    assign unused_exp = bus.wb_exp;
    assign head_exp   = 1'b0;
`endif

    assign retire = (state == RUN) && head_e.valid && head_e.done;
    assign flush  = retire && (head_e.br_taken || head_exp);

    rob_last_writer u_last_writer (
        .ent  (ent),
        .head (head_tag),
        .last (last)
    );

    assign bus.rob_retire               = retire;
    assign bus.commit_en                = retire && head_e.dst_wen && last;
    assign bus.rob_commit_dst_addr_2rat = retire ? head_e.dst_addr : '0;
    assign bus.rob_commit_br_taken      = retire && head_e.br_taken;
    assign bus.rob_commit_exp_en        = retire && head_exp;
    assign bus.rob_commit_tag           = head_tag;

    always_comb begin
        new_e          = '0;
        new_e.valid    = 1'b1;
        new_e.dst_addr = bus.id_dst_addr;
        new_e.dst_wen  = alloc_wen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            head  <= '0;
            tail  <= '0;
            ent   <= '0;
        end else if (flush) begin
            state <= FLUSH;
            head  <= '0;
            tail  <= '0;
            ent   <= '0;
        end else begin
            state <= RUN;
            if (bus.wb_en && ent[bus.wb_tag].valid) begin
                ent[bus.wb_tag].done     <= 1'b1;
                ent[bus.wb_tag].br_taken <= bus.wb_br_taken;
`ifdef ROB_EXP_EN
                ent[bus.wb_tag].exp      <= bus.wb_exp;
`endif
            end
            if (retire) begin
                ent[head_tag] <= '0;
                head          <= head + PTR_W'(1);
            end
            if (bus.allocate_en) begin
                ent[tail_tag] <= new_e;
                tail          <= tail + PTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Randomized and directed bench for rob_ctrl against a queue model.
// Honors ROB_EXP_EN the same way the design does.
module tb_rob_ctrl;

    localparam int D = 8;

    logic clk;
    logic rst_n;
    rob_ctrl_if bus ();

    rob_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] tag;
        logic [4:0] addr;
        logic       wen;
        logic       done;
        logic       br;
        logic       ex;
    } ment_t;

    ment_t mq[$];
    int    mtail;
    bit    mflush;
    int    nchk;
    int    nfail;

    logic       s_ready, s_ae, s_awen, s_ret, s_ce, s_br, s_exp;
    logic [2:0] s_tag, s_ctag;
    logic [4:0] s_aaddr, s_caddr;

    task automatic chk(input string n, input logic [31:0] g,
                       input logic [31:0] e);
        nchk++;
        if (g !== e) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, g, e, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mtail  = 0;
        mflush = 0;
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_ready"}, bus.alloc_ready, 0);
        chk({n, "_alloc_en"}, bus.allocate_en, 0);
        chk({n, "_alloc_tag"}, bus.rob_alloc_tag_2rat, 0);
        chk({n, "_alloc_addr"}, bus.rob_alloc_dst_addr_2rat, 0);
        chk({n, "_alloc_wen"}, bus.rob_alloc_dst_wen_2rat, 0);
        chk({n, "_commit_en"}, bus.commit_en, 0);
        chk({n, "_commit_addr"}, bus.rob_commit_dst_addr_2rat, 0);
        chk({n, "_commit_br"}, bus.rob_commit_br_taken, 0);
        chk({n, "_commit_exp"}, bus.rob_commit_exp_en, 0);
        chk({n, "_commit_tag"}, bus.rob_commit_tag, 0);
        chk({n, "_retire"}, bus.rob_retire, 0);
    endtask

    // Per-cycle compare against the queue model, then advance the model
    task automatic model_step();
        bit rdy, ae, ret, ce, hbr, hex;
        rdy = !mflush && (mq.size() < D);
        ae  = bus.id_alloc_valid && rdy;
        ret = 0;
        ce  = 0;
        hbr = 0;
        hex = 0;
        if (!mflush && mq.size() > 0) ret = mq[0].done;
        if (ret) begin
            ce  = mq[0].wen;
            for (int j = 1; j < mq.size(); j++)
                if (mq[j].wen && mq[j].addr == mq[0].addr) ce = 0;
            hbr = mq[0].br;
`ifdef ROB_EXP_EN
            hex = mq[0].ex;
`endif
        end
        s_ready = bus.alloc_ready;
        s_ae    = bus.allocate_en;
        s_tag   = bus.rob_alloc_tag_2rat;
        s_aaddr = bus.rob_alloc_dst_addr_2rat;
        s_awen  = bus.rob_alloc_dst_wen_2rat;
        s_ret   = bus.rob_retire;
        s_ce    = bus.commit_en;
        s_ctag  = bus.rob_commit_tag;
        s_caddr = bus.rob_commit_dst_addr_2rat;
        s_br    = bus.rob_commit_br_taken;
        s_exp   = bus.rob_commit_exp_en;
        chk("m_ready", s_ready, rdy);
        chk("m_alloc_en", s_ae, ae);
        chk("m_retire", s_ret, ret);
        chk("m_commit_en", s_ce, ce);
        chk("m_commit_br", s_br, hbr);
        chk("m_commit_exp", s_exp, hex);
        if (ae) begin
            chk("m_alloc_tag", s_tag, mtail % D);
            chk("m_alloc_addr", s_aaddr, bus.id_dst_addr);
            chk("m_alloc_wen", s_awen,
                bus.id_dst_wen && bus.id_dst_addr != 0);
        end
        if (ret) begin
            chk("m_commit_tag", s_ctag, mq[0].tag);
            chk("m_commit_addr", s_caddr, mq[0].addr);
        end
        if (ret && (hbr || hex)) begin
            model_clear();
            mflush = 1;
        end else begin
            mflush = 0;
            if (bus.wb_en)
                for (int j = 0; j < mq.size(); j++)
                    if (mq[j].tag == bus.wb_tag) begin
                        mq[j].done = 1;
                        mq[j].br   = bus.wb_br_taken;
                        mq[j].ex   = bus.wb_exp;
                    end
            if (ret) void'(mq.pop_front());
            if (ae) begin
                mq.push_back('{tag: 3'(mtail % D), addr: bus.id_dst_addr,
                    wen: bus.id_dst_wen && bus.id_dst_addr != 0,
                    done: 1'b0, br: 1'b0, ex: 1'b0});
                mtail++;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [4:0] a, input logic w,
                       input logic we, input logic [2:0] wt,
                       input logic br, input logic ex);
        bus.id_alloc_valid = v;
        bus.id_dst_addr    = a;
        bus.id_dst_wen     = w;
        bus.wb_en          = we;
        bus.wb_tag         = wt;
        bus.wb_br_taken    = br;
        bus.wb_exp         = ex;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input string n);
        bus.id_alloc_valid = 0;
        bus.id_dst_addr    = 0;
        bus.id_dst_wen     = 0;
        bus.wb_en          = 0;
        bus.wb_tag         = 0;
        bus.wb_br_taken    = 0;
        bus.wb_exp         = 0;
        rst_n = 0;
        #2;
        chk_zero(n);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_clear();
    endtask

    initial begin
        nchk  = 0;
        nfail = 0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset("rst0");

        // Fill all eight slots, then a ninth request must stall
        for (int i = 0; i < 8; i++) begin
            cyc(1, 5'(i + 1), 1, 0, 0, 0, 0);
            chk("fill_tag", s_tag, i);
            chk("fill_en", s_ae, 1);
        end
        cyc(1, 9, 1, 0, 0, 0, 0);
        chk("full_ready", s_ready, 0);
        chk("full_en", s_ae, 0);

        // Out-of-order completion, in-order retire
        cyc(0, 0, 0, 1, 2, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("ooo_noret", s_ret, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("ooo_ret0", s_ret, 1);
        chk("ooo_tag0", s_ctag, 0);
        chk("ooo_addr0", s_caddr, 1);
        chk("ooo_ce0", s_ce, 1);
        idle();
        chk("ooo_tag1", s_ctag, 1);
        chk("ooo_addr1", s_caddr, 2);
        idle();
        chk("ooo_tag2", s_ctag, 2);
        chk("ooo_addr2", s_caddr, 3);
        chk("ooo_ce2", s_ce, 1);
        idle();
        chk("ooo_stop", s_ret, 0);

        // Older writer of x5 must not clear the younger mapping
        do_reset("rst1");
        cyc(1, 5, 1, 0, 0, 0, 0);
        cyc(1, 6, 1, 0, 0, 0, 0);
        cyc(1, 7, 1, 0, 0, 0, 0);
        cyc(1, 5, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("lw_ret0", s_ret, 1);
        chk("lw_ce0", s_ce, 0);
        cyc(0, 0, 0, 1, 2, 0, 0);
        cyc(0, 0, 0, 1, 3, 0, 0);
        idle();
        chk("lw_ret3", s_ret, 1);
        chk("lw_tag3", s_ctag, 3);
        chk("lw_ce3", s_ce, 1);
        chk("lw_addr3", s_caddr, 5);

        // Branch redirect flush with an allocate in the retire cycle
        do_reset("rst2");
        cyc(1, 1, 1, 0, 0, 0, 0);
        cyc(1, 2, 1, 0, 0, 0, 0);
        cyc(1, 3, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 0);
        chk("br_ret0", s_ret, 1);
        chk("br_nopulse", s_br, 0);
        cyc(1, 9, 1, 0, 0, 0, 0);
        chk("br_pulse", s_br, 1);
        chk("br_tag", s_ctag, 1);
        cyc(1, 9, 1, 0, 0, 0, 0);
        chk("br_flush_ready", s_ready, 0);
        chk("br_flush_pulse", s_br, 0);
        cyc(1, 4, 1, 0, 0, 0, 0);
        chk("br_realloc_en", s_ae, 1);
        chk("br_realloc_tag", s_tag, 0);

        // Exception on the head
        cyc(0, 0, 0, 1, 0, 0, 1);
        idle();
        chk("exp_ret", s_ret, 1);
`ifdef ROB_EXP_EN
        chk("exp_pulse", s_exp, 1);
        idle();
        chk("exp_flush_ready", s_ready, 0);
`else
        chk("exp_pulse", s_exp, 0);
        idle();
        chk("exp_ready", s_ready, 1);
`endif

        // Streaming pairs across pointer wrap
        do_reset("rst3");
        for (int i = 0; i < 20; i++) begin
            cyc(1, 5'((i % 31) + 1), 1, i > 0, 3'((i + 7) % 8), 0, 0);
            chk("wrap_tag", s_tag, i % 8);
            chk("wrap_en", s_ae, 1);
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] wt;
            wt = 3'($urandom_range(0, 7));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                wt = mq[$urandom_range(0, mq.size() - 1)].tag;
            cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6, wt,
                $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
        end

        // Asynchronous reset mid-stream with live inputs
        for (int i = 0; i < 4; i++) cyc(1, 5'(i + 3), 1, 0, 0, 0, 0);
        bus.id_alloc_valid = 1;
        bus.id_dst_addr    = 7;
        bus.id_dst_wen     = 1;
        #2;
        rst_n = 0;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1;
        model_clear();
        cyc(1, 2, 1, 0, 0, 0, 0);
        chk("post_rst_tag", s_tag, 0);
        chk("post_rst_en", s_ae, 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
